// File: rtl/alu_core.sv
// alu_core: 8-bit MIPS-style ALU with registered result and status flags.
//   clk      - system clock, rising edge active
//   rst_n    - asynchronous active-low reset
//   A        - first operand / shift source
//   B        - second operand / shift amount
//   O        - function code (full-width equality decode)
//   Z        - registered result
//   zero     - registered, set when the newly registered Z is zero
//   carry    - registered carry (ADD) / borrow (SUB)
//   overflow - registered signed overflow (ADD/SUB)
module alu_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   O,
  output logic [WIDTH-1:0] Z,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [OPW-1:0] {
    OP_SRL = OPW'(8'h02),
    OP_SRA = OPW'(8'h03),
    OP_ADD = OPW'(8'h20),
    OP_SUB = OPW'(8'h22),
    OP_AND = OPW'(8'h24),
    OP_OR  = OPW'(8'h25),
    OP_XOR = OPW'(8'h26),
    OP_NOR = OPW'(8'h27)
  } op_e;

  logic [WIDTH-1:0] z_d, z_q;
  logic             zero_d, zero_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // One extra bit on each side exposes carry-out / borrow-out directly.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    z_d        = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (O)
      OP_ADD: begin
        z_d        = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        z_d        = diff[WIDTH-1:0];
        carry_d    = diff[WIDTH];
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  z_d = A & B;
      OP_OR:   z_d = A | B;
      OP_XOR:  z_d = A ^ B;
      OP_NOR:  z_d = ~(A | B);
      // Shift amounts >= WIDTH saturate to all-sign / all-zero naturally.
      OP_SRA:  z_d = $signed(A) >>> B;
      OP_SRL:  z_d = A >> B;
      default: z_d = '0;
    endcase
    zero_d = (z_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      z_q        <= z_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign Z        = z_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vector table plus reset and pipelining sequences for alu_core.
module tb_alu_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b, o;
  logic [7:0] z;
  logic       zero, carry, overflow;

  int n_vec  = 0;
  int n_fail = 0;

  alu_core #(.WIDTH(8), .OPW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .O        (o),
    .Z        (z),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic [7:0] z;
    logic       zero;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h", nm, act, req);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] ez, input logic ezero,
                         input logic ec, input logic ev);
    chk({nm, ".Z"}, z, ez);
    chk({nm, ".zero"}, {7'd0, zero}, {7'd0, ezero});
    chk({nm, ".carry"}, {7'd0, carry}, {7'd0, ec});
    chk({nm, ".overflow"}, {7'd0, overflow}, {7'd0, ev});
  endtask

  // Behavioural reference built from integer arithmetic and bit-by-bit shifts.
  function automatic logic [10:0] model(input logic [7:0] ia, input logic [7:0] ib,
                                        input logic [7:0] io);
    logic [7:0] rz;
    logic       rc, rv;
    int         s;
    rz = 8'h00; rc = 1'b0; rv = 1'b0;
    case (io)
      8'h20: begin
        s  = int'(ia) + int'(ib);
        rz = s[7:0];
        rc = (s > 255);
        rv = (ia[7] == ib[7]) && (rz[7] != ia[7]);
      end
      8'h22: begin
        s  = int'(ia) - int'(ib);
        rz = s[7:0];
        rc = (ia < ib);
        rv = (ia[7] != ib[7]) && (rz[7] != ia[7]);
      end
      8'h24: rz = ia & ib;
      8'h25: rz = ia | ib;
      8'h26: rz = ia ^ ib;
      8'h27: rz = ~(ia | ib);
      8'h03: begin
        rz = ia;
        for (int i = 0; i < int'(ib) && i < 8; i++) rz = {rz[7], rz[7:1]};
      end
      8'h02: begin
        rz = ia;
        for (int i = 0; i < int'(ib) && i < 8; i++) rz = {1'b0, rz[7:1]};
      end
      default: rz = 8'h00;
    endcase
    return {rz, (rz == 8'h00), rc, rv};
  endfunction

  initial begin
    logic [7:0]  pa, pb, po;
    logic [10:0] m;
    logic [7:0]  ops[10];

    // Opcode sweep, A=0x0F B=0x01
    vecs.push_back('{8'h0F, 8'h01, 8'h20, 8'h10, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'h01, 8'h21, 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'h01, 8'h22, 8'h0E, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'h01, 8'h23, 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'h01, 8'h24, 8'h01, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'h01, 8'h25, 8'h0F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'h01, 8'h26, 8'h0E, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h0F, 8'h01, 8'h27, 8'hF0, 1'b0, 1'b0, 1'b0});
    // Carry / overflow
    vecs.push_back('{8'hFF, 8'h01, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 8'h20, 8'h80, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 8'h01, 8'h22, 8'hFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 8'h22, 8'h7F, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h05, 8'h05, 8'h22, 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 8'h20, 8'h00, 1'b1, 1'b1, 1'b1});
    // Shifts
    vecs.push_back('{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h02, 8'h02, 8'h20, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h09, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h5A, 8'h00, 8'h03, 8'h5A, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h5A, 8'h00, 8'h02, 8'h5A, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{8'h5A, 8'h03, 8'h03, 8'h0B, 1'b0, 1'b0, 1'b0});
    // Undefined codes
    vecs.push_back('{8'hAA, 8'h55, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hAA, 8'h55, 8'h21, 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hAA, 8'h55, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0});

    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;
    ops[5] = 8'h27; ops[6] = 8'h03; ops[7] = 8'h02; ops[8] = 8'h21; ops[9] = 8'hFF;

    // Reset and first transaction
    rst_n = 1'b0; a = 8'h00; b = 8'h00; o = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_init", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h0F; b = 8'h01; o = 8'h20;
    @(posedge clk); #1;
    chk_all("post_reset_add", 8'h10, 1'b0, 1'b0, 1'b0);

    // Load a state with flags set, then reset asynchronously mid-cycle
    @(negedge clk);
    a = 8'h7F; b = 8'h01; o = 8'h20;
    @(posedge clk); #1;
    chk_all("pre_async_add", 8'h80, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'hFF; b = 8'h01; o = 8'h20;
    @(posedge clk); #2;
    chk_all("pre_async_carry", 8'h00, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    a = 8'h0F; b = 8'h01; o = 8'h20;
    @(posedge clk); #1;
    chk_all("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("reset_release", 8'h10, 1'b0, 1'b0, 1'b0);

    // Directed table, one vector per cycle
    foreach (vecs[i]) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; o = vecs[i].o;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d_op%02h", i, vecs[i].o),
              vecs[i].z, vecs[i].zero, vecs[i].c, vecs[i].v);
    end

    // Pipelining: inputs change right after every edge
    @(negedge clk);
    pa = 8'($urandom); pb = 8'($urandom_range(0, 10)); po = ops[$urandom_range(0, 9)];
    a = pa; b = pb; o = po;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      m = model(pa, pb, po);
      chk_all($sformatf("pipe%0d_op%02h_a%02h_b%02h", k, po, pa, pb),
              m[10:3], m[2], m[1], m[0]);
      pa = 8'($urandom); pb = 8'($urandom_range(0, 10)); po = ops[$urandom_range(0, 9)];
      a = pa; b = pb; o = po;
    end
    @(posedge clk); #1;
    m = model(pa, pb, po);
    chk_all("pipe_last", m[10:3], m[2], m[1], m[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 8-bit MIPS-style arithmetic/logic unit with registered result and status flags.
- Operands A, B and a function code O are presented in parallel.
- The result selected by O appears on Z one clock later.
- Used as the execution datapath block of the processor; the standalone build drives A/B/O from board switches.

Parameters:
- WIDTH, 8, data width of A, B, Z.
- OPW, 8, width of function code O.

Ports:
- clk  in  1  system clock, rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- A  in  WIDTH  first operand; also the shift source.
- B  in  WIDTH  second operand; also the shift amount.
- O  in  OPW  function code.
- Z  out  WIDTH  registered result.
- zero  out  1  registered; 1 when the newly registered Z is 0.
- carry  out  1  registered carry (ADD) / borrow (SUB).
- overflow  out  1  registered signed overflow (ADD/SUB).

Behaviour:
- Reset: rst_n low forces Z=0x00, zero=0, carry=0, overflow=0 immediately, independent of clk. The block stays there while rst_n is low. Release is sampled on the next rising clk edge. Reset mid-operation discards any in-flight result.
- Datapath: combinational compute from the current A, B, O; all outputs registered on every rising clk edge. No enable, no handshake.
- Latency: 1 cycle. Inputs stable before edge n are reflected on outputs after edge n.
- Function decode uses full 8-bit equality on O:
  - 0x20 ADD: Z = A + B mod 256; carry = bit 8 of the 9-bit sum.
  - 0x22 SUB: Z = A - B mod 256; carry = 1 when A < B unsigned (borrow).
  - 0x24 AND: Z = A & B.
  - 0x25 OR: Z = A | B.
  - 0x26 XOR: Z = A ^ B.
  - 0x27 NOR: Z = ~(A | B).
  - 0x03 SRA: Z = A arithmetic right-shifted by B. Sign bit A[7] fills vacated bits. B >= 8 gives all bits = A[7].
  - 0x02 SRL: Z = A logical right-shifted by B. Zero fill. B >= 8 gives 0x00.
  - Any other code (e.g. 0x21, 0x23, 0x00, 0xFF): Z = 0x00, carry = 0, overflow = 0.
- Overflow:
  - ADD: A[7]==B[7] and Z[7]!=A[7].
  - SUB: A[7]!=B[7] and Z[7]!=A[7].
  - All non-ADD/SUB codes: carry = 0, overflow = 0.
- zero: reflects the registered Z for every code, including undefined codes (Z=0 gives zero=1).
- Operands are treated as raw bit vectors. Signedness matters only for overflow and SRA.
- Back-to-back changes of O every cycle are legal. Each edge captures exactly the current inputs; there is no state beyond the output registers.

Test Plan:
- Reset: assert rst_n=0 asynchronously between edges -> Z=0x00, zero=0, carry=0, overflow=0 without waiting for clk. Release, then one edge with A=0x0F, B=0x01, O=0x20 -> Z=0x10.
- Opcode sweep with A=0x0F, B=0x01, O stepping 0x20..0x27 one per cycle -> Z sequence 0x10, 0x00, 0x0E, 0x00, 0x01, 0x0F, 0x0E, 0xF0, each one cycle after its O. zero=1 only for 0x21 and 0x23.
- Carry/overflow:
  - ADD 0xFF+0x01 -> Z=0x00, zero=1, carry=1, overflow=0.
  - ADD 0x7F+0x01 -> Z=0x80, carry=0, overflow=1.
  - SUB 0x00-0x01 -> Z=0xFF, carry=1, overflow=0.
  - SUB 0x80-0x01 -> Z=0x7F, overflow=1.
- Shifts:
  - A=0x80, B=2: SRA -> 0xE0, SRL -> 0x20.
  - A=0x80, B=9: SRA -> 0xFF, SRL -> 0x00.
  - A=0x5A, B=0: both -> 0x5A.
- Latency/pipelining: change A, B, O every cycle for 8 random cycles -> each Z equals the reference model of the inputs sampled at the previous edge. Flags match on every cycle.
- Undefined codes: O=0x00, 0x21, 0xFF with A=0xAA, B=0x55 -> Z=0x00, zero=1, carry=0, overflow=0.
